// File: rtl/johnson_phase_tracker.sv
// rtl/johnson_phase_tracker.sv - Johnson counter phase decoder with lock/direction tracking,
// fault detection and wrap counting for the upstream Johnson down counter.
`timescale 1ns/1ps
module johnson_phase_tracker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8,
  localparam int PHASE_W = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   count_in,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               locked,
  output logic               dir,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic               wrap_pulse,
  output logic [WRAP_W-1:0]  wrap_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(2*WIDTH - 1);
  localparam logic [RUN_W-1:0]   RUN_LOCK = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               cand_dir_q, cand_dir_d;
  logic               dir_q, dir_d;
  logic               ref_valid_q, ref_valid_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]  wrap_count_q, wrap_count_d;

  logic [WIDTH-1:0]   code_inc, code_inv, inv_inc;
  logic               code_legal;
  logic [PHASE_W-1:0] code_phase;
  logic [PHASE_W-1:0] ref_down, ref_up;
  logic               is_hold, is_down, is_up;
  logic               step_dir;
  logic [RUN_W-1:0]   run_next;
  logic               cand_next;

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // A legal code has contiguous ones anchored at the LSB, or contiguous ones
  // anchored at the MSB (i.e. its complement is LSB-anchored).
  always_comb begin
    code_inc   = count_in + WIDTH'(1);
    code_inv   = ~count_in;
    inv_inc    = code_inv + WIDTH'(1);
    code_legal = ((count_in & code_inc) == '0) || ((code_inv & inv_inc) == '0);
    if (count_in == '0 || count_in[0]) begin
      code_phase = PHASE_W'(popcount(count_in));
    end else begin
      code_phase = PHASE_W'(2*WIDTH - popcount(count_in));
    end
  end

  // Neighbours of the reference phase, modulo 2*WIDTH.
  always_comb begin
    ref_down = (phase_q == '0) ? PH_LAST : phase_q - PHASE_W'(1);
    ref_up   = (phase_q == PH_LAST) ? '0 : phase_q + PHASE_W'(1);
    is_hold  = (code_phase == phase_q);
    is_down  = (code_phase == ref_down);
    is_up    = (code_phase == ref_up);
    step_dir = is_down;
  end

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    cand_dir_d    = cand_dir_q;
    dir_d         = dir_q;
    ref_valid_d   = ref_valid_q;
    phase_d       = phase_q;
    phase_valid_d = code_legal;
    err_pulse_d   = 1'b0;
    err_count_d   = err_count_q;
    wrap_pulse_d  = 1'b0;
    wrap_count_d  = wrap_count_q;
    run_next      = run_q;
    cand_next     = cand_dir_q;

    if (code_legal) begin
      phase_d = code_phase;
    end

    case (state_q)
      ST_ACQ: begin
        if (!code_legal) begin
          err_pulse_d = 1'b1;
          run_d       = '0;
          ref_valid_d = 1'b0;
        end else if (!ref_valid_q) begin
          ref_valid_d = 1'b1;
        end else if (is_hold) begin
          run_d = run_q;
        end else if (is_down || is_up) begin
          if (run_q == '0 || step_dir == cand_dir_q) begin
            run_next  = run_q + RUN_W'(1);
            cand_next = step_dir;
          end else begin
            run_next  = RUN_W'(1);
            cand_next = step_dir;
          end
          cand_dir_d = cand_next;
          if (run_next == RUN_LOCK) begin
            state_d = ST_LOCKED;
            dir_d   = cand_next;
            run_d   = '0;
          end else begin
            run_d = run_next;
          end
        end else begin
          run_d = '0;
        end
      end

      ST_LOCKED: begin
        if (code_legal && is_hold) begin
          state_d = ST_LOCKED;
        end else if (code_legal && ((dir_q && is_down) || (!dir_q && is_up))) begin
          // Only a step across the 0 / 2W-1 boundary in the locked direction wraps.
          if ((dir_q && phase_q == '0) || (!dir_q && phase_q == PH_LAST)) begin
            wrap_pulse_d = 1'b1;
            wrap_count_d = wrap_count_q + WRAP_W'(1);
          end
        end else begin
          state_d     = ST_FAULT;
          err_pulse_d = 1'b1;
          run_d       = '0;
          ref_valid_d = 1'b0;
        end
      end

      ST_FAULT: begin
        if (code_legal) begin
          state_d     = ST_ACQ;
          ref_valid_d = 1'b1;
          run_d       = '0;
        end
      end

      default: begin
        state_d     = ST_ACQ;
        run_d       = '0;
        ref_valid_d = 1'b0;
      end
    endcase

    if (err_pulse_d && err_count_q != '1) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ACQ;
      run_q         <= '0;
      cand_dir_q    <= 1'b0;
      dir_q         <= 1'b0;
      ref_valid_q   <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
      wrap_pulse_q  <= 1'b0;
      wrap_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      cand_dir_q    <= cand_dir_d;
      dir_q         <= dir_d;
      ref_valid_q   <= ref_valid_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      err_pulse_q   <= err_pulse_d;
      err_count_q   <= err_count_d;
      wrap_pulse_q  <= wrap_pulse_d;
      wrap_count_q  <= wrap_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = (state_q == ST_LOCKED);
  assign dir         = dir_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign wrap_count  = wrap_count_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// tb/tb_johnson_phase_tracker.sv - directed and random checks of johnson_phase_tracker
// against a phase-table reference model (WIDTH=4, LOCK_CNT=3).
`timescale 1ns/1ps
module tb_johnson_phase_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic [2:0] phase;
  logic       phase_valid, locked, dir, err_pulse, wrap_pulse;
  logic [7:0] err_count, wrap_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Legal Johnson codes in phase order.
  logic [3:0] tbl [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // Model state: 0 = acquiring, 1 = locked, 2 = fault
  int m_state, m_run, m_cand, m_dir, m_refv, m_phase, m_pv;
  int m_errp, m_errc, m_wrapp, m_wrapc;

  johnson_phase_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .phase      (phase),
    .phase_valid(phase_valid),
    .locked     (locked),
    .dir        (dir),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [3:0] c);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_cand = 0; m_dir = 0; m_refv = 0;
    m_phase = 0; m_pv = 0; m_errp = 0; m_errc = 0; m_wrapp = 0; m_wrapc = 0;
  endtask

  task automatic model_step(input logic [3:0] c);
    int idx, d, sd;
    idx = decode(c);
    d = (idx >= 0) ? (idx - m_phase + 8) % 8 : -1;
    m_errp = 0; m_wrapp = 0;
    m_pv = (idx >= 0) ? 1 : 0;
    if (m_state == 0) begin
      if (idx < 0) begin
        m_errp = 1; m_run = 0; m_refv = 0;
      end else if (m_refv == 0) begin
        m_refv = 1;
      end else if (d == 1 || d == 7) begin
        sd = (d == 7) ? 1 : 0;
        if (m_run == 0 || sd == m_cand) m_run++;
        else m_run = 1;
        m_cand = sd;
        if (m_run == 3) begin
          m_state = 1; m_dir = m_cand; m_run = 0;
        end
      end else if (d != 0) begin
        m_run = 0;
      end
    end else if (m_state == 1) begin
      if (idx >= 0 && d == 0) begin
        m_state = 1;
      end else if (idx >= 0 && d == (m_dir ? 7 : 1)) begin
        if ((m_dir == 1 && idx == 7) || (m_dir == 0 && idx == 0)) begin
          m_wrapp = 1; m_wrapc = (m_wrapc + 1) % 256;
        end
      end else begin
        m_state = 2; m_errp = 1; m_run = 0; m_refv = 0;
      end
    end else begin
      if (idx >= 0) begin
        m_state = 0; m_refv = 1; m_run = 0;
      end
    end
    if (idx >= 0) m_phase = idx;
    if (m_errp == 1 && m_errc < 255) m_errc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("phase_valid", 32'(phase_valid), 32'(m_pv));
    chk("locked", 32'(locked), 32'(m_state == 1));
    if (m_state == 1) chk("dir", 32'(dir), 32'(m_dir));
    chk("err_pulse", 32'(err_pulse), 32'(m_errp));
    chk("err_count", 32'(err_count), 32'(m_errc));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrapp));
    chk("wrap_count", 32'(wrap_count), 32'(m_wrapc));
  endtask

  task automatic apply(input logic [3:0] c);
    @(negedge clk);
    count_in = c;
    @(posedge clk);
    model_step(c);
    #1;
    check_all();
  endtask

  task automatic random_run(input int n);
    int r;
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      c = tbl[(m_phase + 7) % 8];
      else if (r == 6) c = tbl[m_phase];
      else if (r == 7) c = tbl[(m_phase + 1) % 8];
      else if (r == 8) c = tbl[$urandom_range(0, 7)];
      else             c = 4'($urandom_range(0, 15));
      apply(c);
    end
  endtask

  initial begin
    rst = 1'b1;
    count_in = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_dir", 32'(dir), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: down sequence locks after the fourth sample
    apply(4'b1111); chk("t1_phase4", 32'(phase), 32'd4);
    apply(4'b0111); chk("t1_phase3", 32'(phase), 32'd3);
    apply(4'b0011); chk("t1_phase2", 32'(phase), 32'd2);
    chk("t1_not_locked", 32'(locked), 32'd0);
    apply(4'b0001); chk("t1_phase1", 32'(phase), 32'd1);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_dir", 32'(dir), 32'd1);

    // 2: wrap
    apply(4'b0000); chk("t2_no_wrap", 32'(wrap_pulse), 32'd0);
    apply(4'b1000); chk("t2_wrap", 32'(wrap_pulse), 32'd1);
    chk("t2_wrap_count", 32'(wrap_count), 32'd1);
    chk("t2_phase7", 32'(phase), 32'd7);

    // 3: step down to 0011 then hold
    apply(4'b1100); apply(4'b1110); apply(4'b1111); apply(4'b0111); apply(4'b0011);
    for (int i = 0; i < 6; i++) begin
      apply(4'b0011);
      chk("t3_locked", 32'(locked), 32'd1);
      chk("t3_no_err", 32'(err_pulse), 32'd0);
      chk("t3_phase2", 32'(phase), 32'd2);
    end

    // 4: illegal code while locked
    apply(4'b0101);
    chk("t4_err", 32'(err_pulse), 32'd1);
    chk("t4_err_count", 32'(err_count), 32'd1);
    chk("t4_unlocked", 32'(locked), 32'd0);
    apply(4'b0101); chk("t4_no_second_err", 32'(err_pulse), 32'd0);
    apply(4'b1100);
    chk("t4_phase6", 32'(phase), 32'd6);
    chk("t4_valid", 32'(phase_valid), 32'd1);

    // 5: reversal while locked, then a jump while acquiring
    apply(4'b1110); apply(4'b1111); apply(4'b0111); apply(4'b0011);
    chk("t5_locked", 32'(locked), 32'd1);
    apply(4'b0111);
    chk("t5_rev_err", 32'(err_pulse), 32'd1);
    chk("t5_rev_err_count", 32'(err_count), 32'd2);
    apply(4'b0000);
    apply(4'b1100); chk("t5_jump_no_err", 32'(err_pulse), 32'd0);
    apply(4'b1110); apply(4'b1111);
    chk("t5_run_reset", 32'(locked), 32'd0);
    apply(4'b0111); chk("t5_relocked", 32'(locked), 32'd1);

    // 6: descend until wrap_count reaches 5, then reset between edges
    for (int i = 0; i < 200 && !(m_state == 1 && m_wrapc == 5); i++) begin
      apply(tbl[(m_phase + 7) % 8]);
    end
    chk("t6_locked", 32'(locked), 32'd1);
    chk("t6_wrap5", 32'(wrap_count), 32'd5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("t6_async_locked", 32'(locked), 32'd0);
    chk("t6_async_wrap", 32'(wrap_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1111);
    apply(4'b0111); chk("t6_step1", 32'(locked), 32'd0);
    apply(4'b0011); chk("t6_step2", 32'(locked), 32'd0);
    apply(4'b0001); chk("t6_step3", 32'(locked), 32'd1);

    random_run(300);

    // err_count saturation under a forced illegal stream while acquiring
    apply(4'b0101);
    apply(4'b0000);
    for (int i = 0; i < 300; i++) apply(4'b0101);
    chk("t6_err_sat", 32'(err_count), 32'd255);
    chk("t6_err_pulse_sat", 32'(err_pulse), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
